pwm_dac: RTL and testbench

- Downstream stage of the DDS sine generator. Consumes each 8-bit Magnitude sample and converts it to a single-bit PWM stream for an external RC low-pass (audio/scope output).
- Holds one sample in a holding register and requests the next sample with a ready/valid handshake. The DDS advances its phase address only when a sample is accepted.
- The duty value is updated only on PWM period boundaries, so the output is glitch-free.

---
 rtl/pwm_dac.sv | 136 +++++++++++++
 tb/tb_pwm_dac.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac.sv
// PWM DAC: converts ready/valid sample stream into a single-bit PWM output.
// Duty is reloaded only at period boundaries from a one-deep holding register.
module pwm_dac #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_req,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [PW-1:0]    pre, pre_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] duty, duty_next;
    logic [WIDTH-1:0] hold, hold_next;
    logic             full, full_next;
    logic             underrun_next;
    logic             pwm_next;
    logic             accept;
    logic             tick;
    logic             entering;
    logic             boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en)  state_next = RUN;
            RUN:     if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pre_next      = pre;
        cnt_next      = cnt;
        duty_next     = duty;
        hold_next     = hold;
        full_next     = full;
        underrun_next = underrun;

        accept   = sample_valid && sample_req;
        tick     = (pre == PRE_LAST);
        entering = (state == IDLE) && en;
        boundary = entering || ((state == RUN) && en && tick && (cnt == CNT_LAST));
        pwm_next = (state == RUN) && en && (cnt < duty);

        if ((state == RUN) && en) begin
            if (tick) begin
                pre_next = '0;
                cnt_next = cnt + 1'b1;
            end else begin
                pre_next = pre + 1'b1;
            end
        end else begin
            pre_next = '0;
            cnt_next = '0;
        end

        if ((state == RUN) && !en) begin
            duty_next = '0;
        end

        if (accept) begin
            hold_next = sample_in;
            full_next = 1'b1;
        end

        // Boundary load reads the old hold; a same-cycle accept refills hold.
        if (boundary) begin
            if (full) begin
                duty_next = hold;
                if (!accept) begin
                    full_next = 1'b0;
                end
            end else if (accept) begin
                duty_next = sample_in;
                hold_next = hold;
                full_next = 1'b0;
            end else if (entering) begin
                duty_next = '0;
            end else begin
                underrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre          <= '0;
            cnt          <= '0;
            duty         <= '0;
            hold         <= '0;
            full         <= 1'b0;
            sample_req   <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            pre          <= pre_next;
            cnt          <= cnt_next;
            duty         <= duty_next;
            hold         <= hold_next;
            full         <= full_next;
            sample_req   <= !full_next;
            pwm_out      <= pwm_next;
            period_start <= boundary;
            underrun     <= underrun_next;
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: constant vector table, directed period
// measurements, and randomized traffic against a cycle-level reference model.
module tb_pwm_dac;

    localparam int P = 1;
    localparam int PERIOD = P * 256;

    logic       clk;
    logic       rst, en, sample_valid;
    logic [7:0] sample_in;
    logic       sample_req, pwm_out, period_start, underrun;

    logic       rst4, en4, valid4;
    logic [7:0] sample4;
    logic       req4, pwm4, ps4, ur4;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_run;
    int m_el, m_duty, m_hold;
    bit m_full, m_ur, m_req, m_pwm, m_ps;

    pwm_dac #(.WIDTH(8), .PRESCALE(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_req(sample_req),
        .pwm_out(pwm_out), .period_start(period_start), .underrun(underrun)
    );

    pwm_dac #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .sample_in(sample4),
        .sample_valid(valid4), .sample_req(req4),
        .pwm_out(pwm4), .period_start(ps4), .underrun(ur4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counts elapsed clocks within a run; counter value and period edge
    // are derived arithmetically from that count.
    task automatic model_step();
        bit acc, ent, wrp, bnd, nfull;
        int cn;
        if (rst) begin
            m_run = 0; m_el = 0; m_duty = 0; m_hold = 0;
            m_full = 0; m_ur = 0; m_req = 0; m_pwm = 0; m_ps = 0;
            return;
        end
        acc   = sample_valid && m_req;
        ent   = !m_run && en;
        wrp   = m_run && en && ((m_el % PERIOD) == PERIOD - 1);
        bnd   = ent || wrp;
        cn    = (m_el / P) % 256;
        m_pwm = m_run && en && (cn < m_duty);
        m_ps  = bnd;
        nfull = m_full;
        if (bnd) begin
            if (m_full) begin
                m_duty = m_hold;
                if (acc) m_hold = int'(sample_in);
                else     nfull = 0;
            end else if (acc) m_duty = int'(sample_in);
            else if (ent)     m_duty = 0;
            else              m_ur = 1;
        end else begin
            if (acc) begin
                m_hold = int'(sample_in);
                nfull  = 1;
            end
            if (m_run && !en) m_duty = 0;
        end
        m_full = nfull;
        m_req  = !nfull;
        if (m_run && !en) begin
            m_run = 0; m_el = 0;
        end else if (ent) begin
            m_run = 1; m_el = 0;
        end else if (m_run) begin
            m_el++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model", int'({sample_req, period_start, pwm_out, underrun}),
              int'({m_req, m_ps, m_pwm, m_ur}));
    endtask

    task automatic reset_dut();
        rst = 1; en = 0; sample_valid = 0; sample_in = 0;
        repeat (3) cycle();
        rst = 0;
        cycle();
    endtask

    task automatic measure(input int n, output int highs, output int pss, output int first_low);
        highs = 0; pss = 0; first_low = 0;
        for (int k = 1; k <= n; k++) begin
            cycle();
            highs += int'(pwm_out);
            pss   += int'(period_start);
            if (!pwm_out && first_low == 0) first_low = k;
        end
    endtask

    task automatic prefill_and_start(input logic [7:0] v);
        sample_valid = 1; sample_in = v;
        cycle();
        sample_valid = 0;
        en = 1;
        cycle();
        check("start_ps", int'(period_start), 1);
    endtask

    typedef struct {
        logic       rst, en, v;
        logic [7:0] s;
        logic       req, ps, pwm, ur;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [7:0] s,
                                input logic req, input logic ps, input logic pwm, input logic ur);
        vec_t t;
        t.rst = r; t.en = e; t.v = v; t.s = s;
        t.req = req; t.ps = ps; t.pwm = pwm; t.ur = ur;
        return t;
    endfunction

    vec_t tbl[13];

    initial begin
        int highs, pss, fl, idx;
        int ph[4];
        bit acc;

        rst4 = 1; en4 = 0; valid4 = 0; sample4 = 0;
        rst = 1; en = 0; sample_valid = 0; sample_in = 0;

        //           rst   en    v     s      req   ps    pwm   ur
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; en = tbl[i].en;
            sample_valid = tbl[i].v; sample_in = tbl[i].s;
            cycle();
            check($sformatf("vec%0d", i), int'({sample_req, period_start, pwm_out, underrun}),
                  int'({tbl[i].req, tbl[i].ps, tbl[i].pwm, tbl[i].ur}));
        end

        // Duty 64: high 64 counts, low 192, next period_start on edge 256
        reset_dut();
        prefill_and_start(8'd64);
        measure(256, highs, pss, fl);
        check("d64_highs", highs, 64);
        check("d64_first_low", fl, 65);
        check("d64_ps_count", pss, 1);
        check("d64_ps_last", int'(period_start), 1);

        // Extremes
        reset_dut();
        prefill_and_start(8'd0);
        measure(512, highs, pss, fl);
        check("d0_highs", highs, 0);
        reset_dut();
        prefill_and_start(8'd255);
        measure(256, highs, pss, fl);
        check("d255_highs", highs, 255);
        check("d255_first_low", fl, 256);

        // Back-to-back: valid held, upstream advances only on accept
        reset_dut();
        idx = 0;
        sample_valid = 1; sample_in = 8'd10; en = 1;
        for (int k = 0; k <= 4 * 256; k++) begin
            acc = sample_valid && sample_req;
            cycle();
            if (acc) begin
                idx++;
                sample_in = 8'(10 * (idx + 1));
            end
            if (k == 0) begin
                for (int p = 0; p < 4; p++) ph[p] = 0;
            end else begin
                ph[(k - 1) / 256] += int'(pwm_out);
            end
        end
        for (int p = 0; p < 4; p++) check($sformatf("b2b_period%0d", p), ph[p], 10 * (p + 1));
        check("b2b_accepts", idx, 5);
        check("b2b_underrun", int'(underrun), 0);
        sample_valid = 0;

        // Underrun: single sample, then starvation
        reset_dut();
        en = 1; sample_valid = 1; sample_in = 8'd100;
        cycle();
        sample_valid = 0;
        measure(255, highs, pss, fl);
        check("ur_before", int'(underrun), 0);
        cycle();
        check("ur_set", int'(underrun), 1);
        measure(256, highs, pss, fl);
        check("ur_duty_kept", highs, 100);
        check("ur_sticky", int'(underrun), 1);
        rst = 1;
        cycle();
        check("ur_cleared", int'(underrun), 0);
        rst = 0;

        // Enable dropped at cnt=100, hold survives, restart from cnt 0
        reset_dut();
        en = 1; sample_valid = 1; sample_in = 8'd50;
        cycle();
        sample_in = 8'd77;
        cycle();
        sample_valid = 0;
        measure(99, highs, pss, fl);
        en = 0;
        cycle();
        check("drop_pwm", int'(pwm_out), 0);
        check("drop_ps", int'(period_start), 0);
        measure(20, highs, pss, fl);
        check("idle_highs", highs, 0);
        check("idle_ps", pss, 0);
        check("idle_req", int'(sample_req), 0);
        en = 1;
        cycle();
        check("restart_ps", int'(period_start), 1);
        measure(256, highs, pss, fl);
        check("restart_highs", highs, 77);
        check("restart_first_low", fl, 78);
        check("restart_ps_count", pss, 1);
        en = 0;

        // PRESCALE=4 instance: period 1024 clocks, high time 4*duty
        cycle();
        rst4 = 0;
        cycle();
        valid4 = 1; sample4 = 8'd50;
        cycle();
        valid4 = 0; en4 = 1;
        cycle();
        check("p4_start_ps", int'(ps4), 1);
        highs = 0; pss = 0; fl = 0;
        for (int k = 1; k <= 1024; k++) begin
            cycle();
            highs += int'(pwm4);
            pss   += int'(ps4);
            if (!pwm4 && fl == 0) fl = k;
        end
        check("p4_highs", highs, 200);
        check("p4_first_low", fl, 201);
        check("p4_ps_count", pss, 1);
        check("p4_ps_last", int'(ps4), 1);
        check("p4_underrun", int'(ur4), 1);
        check("p4_req", int'(req4), 1);
        en4 = 0;

        // Randomized traffic against the reference model
        reset_dut();
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(2499, 0) == 0);
            if ($urandom_range(699, 0) == 0) en = ~en;
            if (k == 5) en = 1;
            sample_valid = ($urandom_range(5, 0) == 0);
            sample_in = 8'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
